dpm_access_ctrl: RTL and testbench

DPM_ACCESS_CTRL -- requirements
Module: dpm_access_ctrl

---
 rtl/dpm_pkg.sv | 20 ++
 rtl/dpm_rr_arb.sv | 35 +++
 rtl/dpm_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dpm_access_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpm_pkg.sv
// Shared widths, latency and request/arbiter types for the dual-port memory
// access controller.
package dpm_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int RSP_LAT = 3;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dpm_req_t;

    typedef enum logic {
        PRIO_0 = 1'b0,
        PRIO_1 = 1'b1
    } dpm_prio_e;

endpackage

// File: rtl/dpm_rr_arb.sv
// Two-way round-robin arbiter; priority moves to the other port after each
// granted conflict.
module dpm_rr_arb
    import dpm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic adv,
    output logic gnt0,
    output logic gnt1
);

    dpm_prio_e prio;
    dpm_prio_e prioNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= PRIO_0;
        end else begin
            prio <= prioNext;
        end
    end

    always_comb begin
        prioNext = prio;
        gnt0     = req0 && (!req1 || (prio == PRIO_0));
        gnt1     = req1 && (!req0 || (prio == PRIO_1));
        if (adv) begin
            prioNext = gnt0 ? PRIO_1 : PRIO_0;
        end
    end

endmodule

// File: rtl/dpm_access_ctrl.sv
// Dual-port memory access controller: per-port 3-stage request/response
// pipeline; simultaneous writes are serialised by a round-robin arbiter.
module dpm_access_ctrl
    import dpm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic              req_we_0,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_0,
    output logic [DATA_W-1:0] rsp_rdata_1,
    output logic              mem_wE_0,
    output logic              mem_wE_1,
    output logic [ADDR_W-1:0] mem_Addr_0,
    output logic [ADDR_W-1:0] mem_Addr_1,
    output logic [DATA_W-1:0] mem_WrData_0,
    output logic [DATA_W-1:0] mem_WrData_1,
    input  logic [DATA_W-1:0] mem_RdData_0,
    input  logic [DATA_W-1:0] mem_RdData_1,
    output logic [7:0]        coll_cnt
);

    dpm_req_t          req [2];
    logic [1:0]        reqValid;
    logic [1:0]        wrReq;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic [1:0]        accept;
    logic              conflict;
    logic [DATA_W-1:0] memRdData [2];

    logic [1:0]        vld_p0;
    logic [1:0]        memWe_p0;
    logic [ADDR_W-1:0] memAddr_p0 [2];
    logic [DATA_W-1:0] memWrData_p0 [2];
    logic [1:0]        fwdEn_p0;
    logic [DATA_W-1:0] fwdData_p0 [2];
    logic [1:0]        vld_p1;
    logic [1:0]        fwdEn_p1;
    logic [DATA_W-1:0] fwdData_p1 [2];
    logic [1:0]        vld_p2;
    logic [DATA_W-1:0] rspData_p2 [2];
    logic [7:0]        collCnt;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        req[0]       = '{we: req_we_0, addr: req_addr_0, wdata: req_wdata_0};
        req[1]       = '{we: req_we_1, addr: req_addr_1, wdata: req_wdata_1};
        reqValid     = {req_valid_1, req_valid_0};
        memRdData[0] = mem_RdData_0;
        memRdData[1] = mem_RdData_1;
    end

    assign wrReq    = reqValid & {req[1].we, req[0].we};
    assign conflict = &wrReq;

    dpm_rr_arb uArb (
        .clk   (clk),
        .reset (reset),
        .req0  (wrReq[0]),
        .req1  (wrReq[1]),
        .adv   (conflict),
        .gnt0  (grant[0]),
        .gnt1  (grant[1])
    );

    always_comb begin
        ready = 2'b00;
        if (!reset) begin
            ready = conflict ? grant : 2'b11;
        end
    end

    assign accept = reqValid & ready;

    // Stage p0: registered memory drive. A read that meets a same-cycle write to
    // the same word on the other port takes that write's data instead of memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0   <= '0;
            memWe_p0 <= '0;
            fwdEn_p0 <= '0;
            for (int p = 0; p < 2; p++) begin
                memAddr_p0[p]   <= '0;
                memWrData_p0[p] <= '0;
                fwdData_p0[p]   <= '0;
            end
        end else begin
            vld_p0   <= accept;
            memWe_p0 <= accept & {req[1].we, req[0].we};
            for (int p = 0; p < 2; p++) begin
                if (accept[p]) begin
                    memAddr_p0[p]   <= req[p].addr;
                    memWrData_p0[p] <= req[p].wdata;
                    fwdEn_p0[p]     <= req[p].we ||
                                       (accept[1-p] && req[1-p].we && (req[1-p].addr == req[p].addr));
                    fwdData_p0[p]   <= req[p].we ? req[p].wdata : req[1-p].wdata;
                end
            end
        end
    end

    // Stage p1: memory access cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= '0;
            fwdEn_p1 <= '0;
            for (int p = 0; p < 2; p++) begin
                fwdData_p1[p] <= '0;
            end
        end else begin
            vld_p1   <= vld_p0;
            fwdEn_p1 <= fwdEn_p0;
            for (int p = 0; p < 2; p++) begin
                fwdData_p1[p] <= fwdData_p0[p];
            end
        end
    end

    // Stage p2: response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2 <= '0;
            for (int p = 0; p < 2; p++) begin
                rspData_p2[p] <= '0;
            end
        end else begin
            vld_p2 <= vld_p1;
            for (int p = 0; p < 2; p++) begin
                if (vld_p1[p]) begin
                    rspData_p2[p] <= fwdEn_p1[p] ? fwdData_p1[p] : memRdData[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collCnt <= '0;
        end else if (conflict) begin
            collCnt <= satInc(collCnt);
        end
    end

    assign req_ready_0  = ready[0];
    assign req_ready_1  = ready[1];
    assign mem_wE_0     = memWe_p0[0];
    assign mem_wE_1     = memWe_p0[1];
    assign mem_Addr_0   = memAddr_p0[0];
    assign mem_Addr_1   = memAddr_p0[1];
    assign mem_WrData_0 = memWrData_p0[0];
    assign mem_WrData_1 = memWrData_p0[1];
    assign rsp_valid_0  = vld_p2[0];
    assign rsp_valid_1  = vld_p2[1];
    assign rsp_rdata_0  = rspData_p2[0];
    assign rsp_rdata_1  = rspData_p2[1];
    assign coll_cnt     = collCnt;

endmodule

// File: tb/tb_dpm_access_ctrl.sv
// Bench for dpm_access_ctrl: behavioural memory, cycle-level scoreboard and
// directed plus random scenarios.
module tb_dpm_access_ctrl;
    import dpm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic       req_we_0, req_we_1;
    logic [3:0] req_addr_0, req_addr_1, req_wdata_0, req_wdata_1;
    logic       rsp_valid_0, rsp_valid_1;
    logic [3:0] rsp_rdata_0, rsp_rdata_1;
    logic       mem_wE_0, mem_wE_1;
    logic [3:0] mem_Addr_0, mem_Addr_1, mem_WrData_0, mem_WrData_1;
    logic [3:0] mem_RdData_0, mem_RdData_1;
    logic [7:0] coll_cnt;

    int vecCnt  = 0;
    int missCnt = 0;

    dpm_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_we_0(req_we_0), .req_we_1(req_we_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
        .mem_wE_0(mem_wE_0), .mem_wE_1(mem_wE_1),
        .mem_Addr_0(mem_Addr_0), .mem_Addr_1(mem_Addr_1),
        .mem_WrData_0(mem_WrData_0), .mem_WrData_1(mem_WrData_1),
        .mem_RdData_0(mem_RdData_0), .mem_RdData_1(mem_RdData_1),
        .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    // Dual-port memory; its reset comes from the same reset at integration level.
    logic [3:0] memArr [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) memArr[i] <= '0;
            mem_RdData_0 <= '0;
            mem_RdData_1 <= '0;
        end else begin
            mem_RdData_0 <= mem_wE_0 ? mem_WrData_0 : memArr[mem_Addr_0];
            mem_RdData_1 <= mem_wE_1 ? mem_WrData_1 : memArr[mem_Addr_1];
            if (mem_wE_0) memArr[mem_Addr_0] <= mem_WrData_0;
            if (mem_wE_1) memArr[mem_Addr_1] <= mem_WrData_1;
        end
    end

    // Reference model: per cycle, pick accepted requests, apply writes to a
    // shadow memory in request order, and expect each response RSP_LAT later.
    typedef struct {
        int         due;
        logic [3:0] data;
    } exp_t;
    exp_t       q0[$];
    exp_t       q1[$];
    logic [3:0] shadow [16];
    int         cyc   = 0;
    int         prioM = 0;
    int         collM = 0;
    logic       w0, w1, cf, er0, er1, ev0, ev1;
    logic [37:0] allOut;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            allOut = {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
                      mem_wE_0, mem_wE_1, mem_Addr_0, mem_Addr_1, mem_WrData_0, mem_WrData_1, coll_cnt};
            vecCnt++;
            if (allOut !== '0) begin
                missCnt++;
                $display("FAIL reset_outputs: got %h want 0", allOut);
            end
            q0.delete();
            q1.delete();
            prioM = 0;
            collM = 0;
            for (int i = 0; i < 16; i++) shadow[i] = '0;
        end else begin
            w0  = req_valid_0 && req_we_0;
            w1  = req_valid_1 && req_we_1;
            cf  = w0 && w1;
            er0 = !cf || (prioM == 0);
            er1 = !cf || (prioM == 1);
            vecCnt++;
            if ({req_ready_1, req_ready_0} !== {er1, er0}) begin
                missCnt++;
                $display("FAIL ready cyc %0d: got %b%b want %b%b", cyc, req_ready_1, req_ready_0, er1, er0);
            end
            vecCnt++;
            if (coll_cnt !== collM[7:0]) begin
                missCnt++;
                $display("FAIL coll_cnt cyc %0d: got %0d want %0d", cyc, coll_cnt, collM);
            end
            vecCnt++;
            if (mem_wE_0 === 1'b1 && mem_wE_1 === 1'b1) begin
                missCnt++;
                $display("FAIL dual_write cyc %0d: got wE 11 want not both", cyc);
            end
            ev0 = (q0.size() > 0) && (q0[0].due == cyc);
            ev1 = (q1.size() > 0) && (q1[0].due == cyc);
            vecCnt++;
            if ({rsp_valid_1, rsp_valid_0} !== {ev1, ev0}) begin
                missCnt++;
                $display("FAIL rsp_valid cyc %0d: got %b%b want %b%b", cyc, rsp_valid_1, rsp_valid_0, ev1, ev0);
            end
            if (ev0) begin
                vecCnt++;
                if (rsp_rdata_0 !== q0[0].data) begin
                    missCnt++;
                    $display("FAIL rsp_rdata_0 cyc %0d: got %h want %h", cyc, rsp_rdata_0, q0[0].data);
                end
                void'(q0.pop_front());
            end
            if (ev1) begin
                vecCnt++;
                if (rsp_rdata_1 !== q1[0].data) begin
                    missCnt++;
                    $display("FAIL rsp_rdata_1 cyc %0d: got %h want %h", cyc, rsp_rdata_1, q1[0].data);
                end
                void'(q1.pop_front());
            end
            if (req_valid_0 && er0 && req_we_0) shadow[req_addr_0] = req_wdata_0;
            if (req_valid_1 && er1 && req_we_1) shadow[req_addr_1] = req_wdata_1;
            if (req_valid_0 && er0) q0.push_back(exp_t'{cyc + RSP_LAT, shadow[req_addr_0]});
            if (req_valid_1 && er1) q1.push_back(exp_t'{cyc + RSP_LAT, shadow[req_addr_1]});
            if (cf) begin
                prioM = 1 - prioM;
                if (collM < 255) collM++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic we, input logic [3:0] a, input logic [3:0] d);
        if (p == 0) begin
            req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
        end else begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    task automatic setIdle();
        drive(0, 1'b0, 1'b0, 4'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        setIdle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 4'h2, 4'h5);
        drive(1, 1'b1, 1'b1, 4'h3, 4'h6);
        tick();
        tick();
        vecCnt++;
        if ({req_ready_0, req_ready_1, mem_wE_0, mem_wE_1, rsp_valid_0, rsp_valid_1, coll_cnt} !== '0) begin
            missCnt++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b%b %h want all 0", req_ready_0, req_ready_1,
                     mem_wE_0, mem_wE_1, rsp_valid_0, rsp_valid_1, coll_cnt);
        end
        reset = 1'b0;
        setIdle();
        drive(0, 1'b1, 1'b1, 4'h2, 4'h5);
        #1;
        vecCnt++;
        if (req_ready_0 !== 1'b1) begin
            missCnt++;
            $display("FAIL first_accept: got ready_0 %b want 1", req_ready_0);
        end
        tick();
        setIdle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_write_then_read();
        applyReset();
        drive(0, 1'b1, 1'b1, 4'h3, 4'hA);
        tick();
        vecCnt++;
        if ({mem_wE_0, mem_Addr_0, mem_WrData_0} !== {1'b1, 4'h3, 4'hA}) begin
            missCnt++;
            $display("FAIL mem_drive_0: got %b %h %h want 1 3 a", mem_wE_0, mem_Addr_0, mem_WrData_0);
        end
        setIdle();
        drive(1, 1'b1, 1'b0, 4'h3, 4'h0);
        tick();
        setIdle();
        vecCnt++;
        if ({mem_wE_0, mem_Addr_0} !== {1'b0, 4'h3}) begin
            missCnt++;
            $display("FAIL mem_hold_0: got %b %h want 0 3", mem_wE_0, mem_Addr_0);
        end
        tick();
        vecCnt++;
        if ({rsp_valid_0, rsp_rdata_0} !== {1'b1, 4'hA}) begin
            missCnt++;
            $display("FAIL raw_rsp0: got %b %h want 1 a", rsp_valid_0, rsp_rdata_0);
        end
        tick();
        vecCnt++;
        if ({rsp_valid_0, rsp_valid_1, rsp_rdata_1} !== {1'b0, 1'b1, 4'hA}) begin
            missCnt++;
            $display("FAIL raw_rsp1: got %b %b %h want 0 1 a", rsp_valid_0, rsp_valid_1, rsp_rdata_1);
        end
        tick();
    endtask

    task automatic test_conflict_pair();
        applyReset();
        drive(0, 1'b1, 1'b1, 4'h5, 4'h1);
        drive(1, 1'b1, 1'b1, 4'h5, 4'h2);
        #1;
        vecCnt++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            missCnt++;
            $display("FAIL conflict_grant: got %b%b want 10", req_ready_0, req_ready_1);
        end
        tick();
        drive(0, 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        vecCnt++;
        if (req_ready_1 !== 1'b1) begin
            missCnt++;
            $display("FAIL retry_grant: got ready_1 %b want 1", req_ready_1);
        end
        tick();
        setIdle();
        tick();
        tick();
        vecCnt++;
        if (coll_cnt !== 8'd1) begin
            missCnt++;
            $display("FAIL coll_one: got %0d want 1", coll_cnt);
        end
        drive(0, 1'b1, 1'b0, 4'h5, 4'h0);
        tick();
        setIdle();
        tick();
        tick();
        vecCnt++;
        if ({rsp_valid_0, rsp_rdata_0} !== {1'b1, 4'h2}) begin
            missCnt++;
            $display("FAIL read_after_conflict: got %b %h want 1 2", rsp_valid_0, rsp_rdata_0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b1, 4'(i), 4'($urandom_range(0, 15)));
            drive(1, 1'b1, 1'b1, 4'(i + 8), 4'($urandom_range(0, 15)));
            #1;
            vecCnt++;
            if ({req_ready_0, req_ready_1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                missCnt++;
                $display("FAIL alternate %0d: got %b%b want %s", i, req_ready_0, req_ready_1,
                         (i % 2 == 0) ? "10" : "01");
            end
            tick();
        end
        setIdle();
        tick();
        vecCnt++;
        if (coll_cnt !== 8'd4) begin
            missCnt++;
            $display("FAIL coll_four: got %0d want 4", coll_cnt);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_read_write_same();
        applyReset();
        drive(0, 1'b1, 1'b0, 4'h7, 4'h0);
        drive(1, 1'b1, 1'b1, 4'h7, 4'hC);
        #1;
        vecCnt++;
        if ({req_ready_0, req_ready_1} !== 2'b11) begin
            missCnt++;
            $display("FAIL rw_ready: got %b%b want 11", req_ready_0, req_ready_1);
        end
        tick();
        setIdle();
        tick();
        tick();
        vecCnt++;
        if ({rsp_valid_0, rsp_rdata_0, rsp_valid_1, rsp_rdata_1} !== {1'b1, 4'hC, 1'b1, 4'hC}) begin
            missCnt++;
            $display("FAIL rw_same: got %b %h %b %h want 1 c 1 c", rsp_valid_0, rsp_rdata_0,
                     rsp_valid_1, rsp_rdata_1);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        applyReset();
        drive(0, 1'b1, 1'b0, 4'h1, 4'h0);
        drive(1, 1'b1, 1'b0, 4'h2, 4'h0);
        tick();
        setIdle();
        tick();
        reset = 1'b1;
        #1;
        vecCnt++;
        if ({rsp_valid_0, rsp_valid_1, mem_wE_0, mem_wE_1, mem_Addr_0, mem_Addr_1} !== '0) begin
            missCnt++;
            $display("FAIL inflight_reset: got %b%b%b%b %h %h want 0", rsp_valid_0, rsp_valid_1,
                     mem_wE_0, mem_wE_1, mem_Addr_0, mem_Addr_1);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vecCnt++;
            if ({rsp_valid_0, rsp_valid_1} !== 2'b00) begin
                missCnt++;
                $display("FAIL dropped_rsp %0d: got %b%b want 00", i, rsp_valid_0, rsp_valid_1);
            end
        end
        drive(0, 1'b1, 1'b1, 4'h4, 4'h9);
        drive(1, 1'b1, 1'b1, 4'h4, 4'h6);
        #1;
        vecCnt++;
        if ({req_ready_0, req_ready_1} !== 2'b10) begin
            missCnt++;
            $display("FAIL post_reset_grant: got %b%b want 10", req_ready_0, req_ready_1);
        end
        tick();
        setIdle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_saturate();
        applyReset();
        for (int i = 0; i < 300; i++) begin
            drive(0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drive(1, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
        end
        setIdle();
        tick();
        vecCnt++;
        if (coll_cnt !== 8'd255) begin
            missCnt++;
            $display("FAIL coll_saturate: got %0d want 255", coll_cnt);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        applyReset();
        for (int i = 0; i < 500; i++) begin
            drive(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            drive(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            tick();
        end
        setIdle();
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_conflict_pair();
        test_back_to_back();
        test_read_write_same();
        test_reset_inflight();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
